// File: rtl/sdf_accum_rr_if.sv
// Read-side (input FIFO bank) and write-side (output FIFO) handshake bundles for sdf_accum_rr.
// The master modport is the accumulator's view; the slave modport is the FIFO side.
interface sdf_accum_rr_rd_if #(
  parameter int WIDTH = 9,
  parameter int PORTS = 2,
  parameter int FLUX  = 2
);
  logic [WIDTH*PORTS*FLUX-1:0] dout;
  logic [PORTS*FLUX-1:0]       empty;
  logic [PORTS*FLUX-1:0]       read;

  modport master (input dout, input empty, output read);
  modport slave  (output dout, output empty, input read);
endinterface

interface sdf_accum_rr_wr_if #(
  parameter int WIDTH = 9,
  parameter int FLUX  = 2
);
  logic [FLUX-1:0]  full;
  logic             write;
  logic [WIDTH-1:0] din;

  modport master (input full, output write, output din);
  modport slave  (output full, input write, input din);
endinterface

// File: rtl/sdf_accum_rr.sv
// Round-robin multi-flux accumulator: one ready flux per cycle pops all its ports,
// adds the payloads into that flux's running sum and pushes {tag, result} with zero latency.
module sdf_accum_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int NUM_OP     = 4,
  parameter int OUT_MODE   = 0,
  parameter int SAT        = 0
) (
  input  logic              clk,
  input  logic              rst,
  sdf_accum_rr_rd_if.master read_port,
  sdf_accum_rr_wr_if.master write_port,
  output logic [FLUX-1:0]   ovf
);

  localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1;
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int CW        = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;
  localparam int SUM_W     = DATA_WIDTH + $clog2(PORTS + 1);
  localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [DATA_WIDTH-1:0] acc [FLUX];
  logic [CW-1:0]         cnt [FLUX];
  logic [TAG_WIDTH-1:0]  ptr;
  logic [TAG_WIDTH-1:0]  tag;
  logic [FLUX-1:0]       ready;
  logic                  fire;
  logic                  last;
  logic                  over;
  logic                  push;
  logic                  wr_en;
  logic [SUM_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] result;
  logic                  unused_dout;

  // Upper bits of each input word carry the producer's tag and play no part in the sum.
  assign unused_dout = ^read_port.dout;

  always_comb begin
    for (int f = 0; f < FLUX; f++) begin
      ready[f] = ~|read_port.empty[f*PORTS +: PORTS] & ~write_port.full[f];
    end
  end

  // Search starts at ptr and wraps; with nothing ready tag rests on ptr.
  always_comb begin
    fire = 1'b0;
    tag  = ptr;
    for (int k = 0; k < FLUX; k++) begin
      int idx;
      idx = (int'(ptr) + k) % FLUX;
      if (!fire && ready[idx]) begin
        fire = 1'b1;
        tag  = TAG_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    sum = SUM_W'(acc[tag]);
    for (int p = 0; p < PORTS; p++) begin
      sum = sum + SUM_W'(read_port.dout[(p + int'(tag)*PORTS)*WIDTH +: DATA_WIDTH]);
    end
    over   = (sum > MAX_VAL);
    result = ((SAT != 0) && over) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
    last   = (cnt[tag] == '0);
  end

  // Handshake outputs are gated by reset so nothing pops or pushes while it is held.
  always_comb begin
    push             = fire & ((OUT_MODE == 0) | last);
    wr_en            = rst & push;
    write_port.write = wr_en;
    write_port.din   = {tag, (wr_en ? result : acc[tag])};
    read_port.read   = '0;
    if (rst && fire) begin
      read_port.read[int'(tag)*PORTS +: PORTS] = {PORTS{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      ovf <= '0;
      for (int f = 0; f < FLUX; f++) begin
        acc[f] <= '0;
        cnt[f] <= CW'(NUM_OP - 1);
      end
    end else if (fire) begin
      ptr <= (int'(tag) == FLUX - 1) ? '0 : tag + 1'b1;
      if (over) begin
        ovf[tag] <= 1'b1;
      end
      if (last) begin
        acc[tag] <= '0;
        cnt[tag] <= CW'(NUM_OP - 1);
      end else begin
        acc[tag] <= result;
        cnt[tag] <= cnt[tag] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdf_accum_rr.sv
// Self-checking bench: a wrapping/every-firing DUT and a saturating/window-end DUT share
// the same input FIFO stimulus; a reference model feeds per-DUT scoreboard queues.
module tb_sdf_accum_rr;

  localparam int DW     = 8;
  localparam int FLUX   = 2;
  localparam int PORTS  = 2;
  localparam int NUM_OP = 4;
  localparam int WIDTH  = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [PORTS*FLUX-1:0]       empty = '1;
  logic [FLUX-1:0]             full  = '0;
  logic [WIDTH*PORTS*FLUX-1:0] dout  = '0;
  logic [FLUX-1:0]             ovf_a;
  logic [FLUX-1:0]             ovf_b;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] q_a [$];
  logic [WIDTH-1:0] q_b [$];

  int              m_acc [2][FLUX];
  int              m_cnt [FLUX];
  int              m_ptr;
  logic [FLUX-1:0] m_ovf [2];

  always #5 clk = ~clk;

  sdf_accum_rr_rd_if #(.WIDTH(WIDTH), .PORTS(PORTS), .FLUX(FLUX)) rd_a ();
  sdf_accum_rr_rd_if #(.WIDTH(WIDTH), .PORTS(PORTS), .FLUX(FLUX)) rd_b ();
  sdf_accum_rr_wr_if #(.WIDTH(WIDTH), .FLUX(FLUX)) wr_a ();
  sdf_accum_rr_wr_if #(.WIDTH(WIDTH), .FLUX(FLUX)) wr_b ();

  assign rd_a.dout  = dout;
  assign rd_a.empty = empty;
  assign wr_a.full  = full;
  assign rd_b.dout  = dout;
  assign rd_b.empty = empty;
  assign wr_b.full  = full;

  sdf_accum_rr #(.DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NUM_OP),
                 .OUT_MODE(0), .SAT(0)) dut_a (
    .clk(clk), .rst(rst), .read_port(rd_a), .write_port(wr_a), .ovf(ovf_a));

  sdf_accum_rr #(.DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NUM_OP),
                 .OUT_MODE(1), .SAT(1)) dut_b (
    .clk(clk), .rst(rst), .read_port(rd_b), .write_port(wr_b), .ovf(ovf_b));

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      m_ovf[m] = '0;
      for (int f = 0; f < FLUX; f++) m_acc[m][f] = 0;
    end
    for (int f = 0; f < FLUX; f++) m_cnt[f] = NUM_OP - 1;
    m_ptr = 0;
  endtask

  // Model index 0 = wrap/every firing (dut_a), 1 = saturate/window end (dut_b).
  task automatic applyStimulus(input logic [3:0] emp, input logic [1:0] fl,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] b0, input logic [7:0] b1);
    int              pay [FLUX][PORTS];
    logic [3:0]      exp_read;
    logic [1:0]      exp_write;
    logic [FLUX-1:0] exp_ovf [2];
    bit              fire;
    int              tag;
    int              sum;
    int              res;
    @(negedge clk);
    empty = emp;
    full  = fl;
    dout  = {1'b1, b1, 1'b1, b0, 1'b1, a1, 1'b1, a0};
    pay[0][0] = a0; pay[0][1] = a1; pay[1][0] = b0; pay[1][1] = b1;
    exp_read   = '0;
    exp_write  = '0;
    exp_ovf[0] = m_ovf[0];
    exp_ovf[1] = m_ovf[1];
    if (rst) begin
      fire = 1'b0;
      tag  = m_ptr;
      for (int k = 0; k < FLUX; k++) begin
        int idx;
        idx = (m_ptr + k) % FLUX;
        if (!fire && emp[idx*PORTS +: PORTS] == '0 && !fl[idx]) begin
          fire = 1'b1;
          tag  = idx;
        end
      end
      if (fire) begin
        exp_read[tag*PORTS +: PORTS] = '1;
        for (int m = 0; m < 2; m++) begin
          sum = m_acc[m][tag] + pay[tag][0] + pay[tag][1];
          res = (sum > 255) ? ((m == 1) ? 255 : sum % 256) : sum;
          if (sum > 255) m_ovf[m][tag] = 1'b1;
          if (m == 0 || m_cnt[tag] == 0) begin
            exp_write[m] = 1'b1;
            if (m == 0) q_a.push_back({1'(tag), 8'(res)});
            else        q_b.push_back({1'(tag), 8'(res)});
          end
          m_acc[m][tag] = (m_cnt[tag] == 0) ? 0 : res;
        end
        m_cnt[tag] = (m_cnt[tag] == 0) ? NUM_OP - 1 : m_cnt[tag] - 1;
        m_ptr      = (tag + 1) % FLUX;
      end
    end
    #2;
    checkOutput("read_a", 32'(rd_a.read), 32'(exp_read));
    checkOutput("read_b", 32'(rd_b.read), 32'(exp_read));
    checkOutput("write_a", 32'(wr_a.write), 32'(exp_write[0]));
    checkOutput("write_b", 32'(wr_b.write), 32'(exp_write[1]));
    checkOutput("ovf_a", 32'(ovf_a), 32'(exp_ovf[0]));
    checkOutput("ovf_b", 32'(ovf_b), 32'(exp_ovf[1]));
    if (wr_a.write === 1'b1) begin
      if (q_a.size() == 0) checkOutput("din_a_queue", 32'(q_a.size()), 32'd1);
      else                 checkOutput("din_a", 32'(wr_a.din), 32'(q_a.pop_front()));
    end
    if (wr_b.write === 1'b1) begin
      if (q_b.size() == 0) checkOutput("din_b_queue", 32'(q_b.size()), 32'd1);
      else                 checkOutput("din_b", 32'(wr_b.din), 32'(q_b.pop_front()));
    end
  endtask

  // Assert reset with the previous (ready) inputs still applied; release with all FIFOs empty.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rst_read_a", 32'(rd_a.read), 32'd0);
    checkOutput("rst_read_b", 32'(rd_b.read), 32'd0);
    checkOutput("rst_write_a", 32'(wr_a.write), 32'd0);
    checkOutput("rst_write_b", 32'(wr_b.write), 32'd0);
    checkOutput("rst_ovf_a", 32'(ovf_a), 32'd0);
    checkOutput("rst_ovf_b", 32'(ovf_b), 32'd0);
    @(negedge clk);
    empty = '1;
    full  = '0;
    rst   = 1'b1;
    modelReset();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    applyStimulus(4'b1100, 2'b00, 8'd1, 8'd2, 8'd0, 8'd0);
    doReset();

    repeat (5) applyStimulus(4'b1100, 2'b00, 8'd1, 8'd2, 8'd0, 8'd0);
    doReset();

    repeat (8) applyStimulus(4'b0000, 2'b00, 8'd1, 8'd1, 8'd2, 8'd3);
    doReset();

    repeat (4) applyStimulus(4'b1100, 2'b00, 8'd200, 8'd100, 8'd0, 8'd0);
    repeat (2) applyStimulus(4'b1111, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    doReset();

    repeat (4) applyStimulus(4'b0000, 2'b10, 8'd5, 8'd6, 8'd7, 8'd8);
    repeat (3) applyStimulus(4'b0000, 2'b00, 8'd5, 8'd6, 8'd7, 8'd8);
    doReset();

    repeat (2) applyStimulus(4'b1100, 2'b00, 8'd1, 8'd2, 8'd0, 8'd0);
    doReset();
    repeat (4) applyStimulus(4'b1100, 2'b00, 8'd1, 8'd2, 8'd0, 8'd0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] emp;
      logic [1:0] fl;
      emp = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      fl  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      applyStimulus(emp, fl, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    checkOutput("q_a_left", 32'(q_a.size()), 32'd0);
    checkOutput("q_b_left", 32'(q_b.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdf_accum_rr.md
SDF_ACCUM_RR -- requirements
Module: sdf_accum_rr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the payload bits per token.
REQ-002 SHALL have parameter FLUX, default 2, meaning the number of independent data flows, each with its own tag.
REQ-003 SHALL have parameter PORTS, default 2, meaning the input ports per flux.
REQ-004 SHALL have parameter NUM_OP, default 4, meaning the firings per accumulation window (NUM_OP>=1).
REQ-005 SHALL have parameter OUT_MODE, default 0, meaning 0 = emit the running sum on every firing and 1 = emit only on the last firing of the window.
REQ-006 SHALL have parameter SAT, default 0, meaning 0 = wrap modulo 2^DATA_WIDTH and 1 = saturate to 2^DATA_WIDTH-1.
REQ-007 SHALL derive TAG_WIDTH=max(1,clog2(FLUX)), WIDTH=DATA_WIDTH+TAG_WIDTH and CW=max(1,clog2(NUM_OP)).
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port read_port.dout, input, WIDTH*PORTS*FLUX bits: the word for flux f, port p, at slice index p+f*PORTS; the low DATA_WIDTH bits are payload.
REQ-011 SHALL have port read_port.empty, input, PORTS*FLUX bits: bit p+f*PORTS high = that FIFO is empty.
REQ-012 SHALL have port read_port.read, output, PORTS*FLUX bits: pops; same bit ordering as empty.
REQ-013 SHALL have port write_port.full, input, FLUX bits: bit f high = the output FIFO for flux f is full.
REQ-014 SHALL have port write_port.write, output, 1 bit: push strobe.
REQ-015 SHALL have port write_port.din, output, WIDTH bits: {tag, result}.
REQ-016 SHALL have port ovf, output, FLUX bits: sticky flag, one per flux, for overflow (wrap or saturation).

Function
REQ-017 Flux f SHALL be ready when all its PORTS empty bits are 0 and full[f]=0.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer ptr; the first ready flux found becomes tag; on firing, ptr <= (tag+1) mod FLUX; with no ready flux, ptr holds.
REQ-019 A firing SHALL assert read for all PORTS bits of tag in the same cycle (first-word-fall-through); all other read bits SHALL be 0; with no ready flux, all read bits SHALL be 0.
REQ-020 Per flux, the block SHALL keep acc[f] (DATA_WIDTH bits) and cnt[f] (CW bits), counting down NUM_OP-1..0.
REQ-021 On firing, sum SHALL be acc[tag] plus the PORTS payloads of tag, computed without loss at DATA_WIDTH+clog2(PORTS+1) bits, then wrapped or saturated per SAT to give result.
REQ-022 If sum exceeds 2^DATA_WIDTH-1 on a firing, ovf[tag] SHALL set at the next edge and stay set until reset.
REQ-023 On a non-last firing (cnt[tag]!=0): acc[tag]<=result and cnt[tag]<=cnt[tag]-1; write=1 only if OUT_MODE=0.
REQ-024 On the last firing (cnt[tag]==0): write=1 with result, acc[tag]<=0 and cnt[tag]<=NUM_OP-1; NUM_OP=1 makes every firing last.
REQ-025 The write, din and read outputs SHALL be combinational in the firing cycle, giving zero-cycle latency from ready to push.
REQ-026 When write=0, din SHALL be {tag, acc[tag]}; only non-firing fluxes' state SHALL be held.
REQ-027 Firing SHALL require full[tag]=0 even for silent firings in OUT_MODE=1.
REQ-028 Reading empty FIFOs or writing a full FIFO SHALL be impossible by construction.

Reset
REQ-029 While rst=0 (asynchronous): acc[*]=0, cnt[*]=NUM_OP-1, ptr=0, ovf=0.
REQ-030 While rst=0, write and all read bits SHALL be forced to 0 regardless of the inputs.
REQ-031 Reset asserted mid-window SHALL discard partial sums; the first post-reset firing starts a new window.

Verification (DATA_WIDTH=8, FLUX=2, PORTS=2, NUM_OP=4)
REQ-032 Flux0 only, payloads (1,2), OUT_MODE=0, five firings -> din = {0,3},{0,6},{0,9},{0,12},{0,3}.
REQ-033 Same stimulus with OUT_MODE=1 -> exactly one write, {0,12}, on the 4th firing; read pulses on all 4 firings.
REQ-034 Both fluxes continuously ready -> tags alternate 0,1,0,1; each flux's window completes on its own 4th firing.
REQ-035 Payloads (200,100): SAT=1 -> result 255, ovf[0]=1; SAT=0 -> result 44, ovf[0]=1; ovf[1] stays 0.
REQ-036 full[1]=1 with flux1 data present -> flux1 read bits stay 0; flux0 fires every cycle; releasing full[1] -> flux1 fires on the next cycle ptr grants it.
REQ-037 rst pulsed low after 2 flux0 firings (payloads 1,2) -> outputs drop immediately; the next firing yields {0,3} and cnt restarts at 3.
